// File: rtl/window_align_stream.sv
// Streaming window aligner: stitches consecutive beats of a row into windows shifted
// left by a per-row offset, with valid/ready handshakes and a zero-filled end-of-row flush.
module window_align_stream #(
   parameter int WORDS       = 16,
   parameter int WORD_SIZE   = 8,
   parameter int INDEX_WIDTH = 10,
   parameter int OFF_WIDTH   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [OFF_WIDTH-1:0]         cfg_offset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WORDS*WORD_SIZE-1:0]   in_wdata,
   input  logic [INDEX_WIDTH-1:0]       in_waddrY,
   input  logic [INDEX_WIDTH-1:0]       in_waddrBlock,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WORDS*WORD_SIZE-1:0]   out_wdata,
   output logic [INDEX_WIDTH-1:0]       out_waddrY,
   output logic [INDEX_WIDTH-1:0]       out_waddrBlock,
   output logic                         out_last,
   output logic                         busy
);

   typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

   state_t                              state_reg;
   logic [WORDS-1:0][WORD_SIZE-1:0]     held_reg;
   logic [INDEX_WIDTH-1:0]              held_y_reg;
   logic [INDEX_WIDTH-1:0]              held_blk_reg;
   logic [OFF_WIDTH-1:0]                off_reg;

   logic                                out_valid_reg;
   logic [WORDS-1:0][WORD_SIZE-1:0]     out_wdata_reg;
   logic [INDEX_WIDTH-1:0]              out_y_reg;
   logic [INDEX_WIDTH-1:0]              out_blk_reg;
   logic                                out_last_reg;

   logic                                slot_free;
   logic [OFF_WIDTH:0]                  off_ext;
   logic [OFF_WIDTH-1:0]                off_sel;
   logic [WORDS-1:0][WORD_SIZE-1:0]     cur_words;
   logic [2*WORDS-1:0][WORD_SIZE-1:0]   pair;
   logic [WORDS-1:0][WORD_SIZE-1:0]     window;

   assign slot_free = !out_valid_reg || out_ready;

   // Out-of-range offsets saturate to the largest legal shift.
   assign off_ext = {1'b0, cfg_offset};
   assign off_sel = (off_ext >= (OFF_WIDTH+1)'(WORDS)) ? OFF_WIDTH'(WORDS-1) : cfg_offset;

   // The flush window pulls zeros in place of a following beat.
   assign cur_words = (state_reg == FLUSH) ? '0 : in_wdata;
   assign pair      = {cur_words, held_reg};

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
         logic [OFF_WIDTH:0] idx;
         assign idx        = (OFF_WIDTH+1)'(gi) + {1'b0, off_reg};
         assign window[gi] = pair[idx];
      end
   endgenerate

   always_comb begin
      in_ready = 1'b0;
      if (reset_n) begin
         case (state_reg)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = slot_free;
            default: in_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         held_reg      <= '0;
         held_y_reg    <= '0;
         held_blk_reg  <= '0;
         off_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_wdata_reg <= '0;
         out_y_reg     <= '0;
         out_blk_reg   <= '0;
         out_last_reg  <= 1'b0;
      end else begin
         if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  held_reg     <= in_wdata;
                  held_y_reg   <= in_waddrY;
                  held_blk_reg <= in_waddrBlock;
                  off_reg      <= off_sel;
                  state_reg    <= in_last ? FLUSH : HOLD;
               end
            end
            HOLD: begin
               if (in_valid && slot_free) begin
                  out_valid_reg <= 1'b1;
                  out_wdata_reg <= window;
                  out_y_reg     <= held_y_reg;
                  out_blk_reg   <= held_blk_reg;
                  out_last_reg  <= 1'b0;
                  held_reg      <= in_wdata;
                  held_y_reg    <= in_waddrY;
                  held_blk_reg  <= in_waddrBlock;
                  state_reg     <= in_last ? FLUSH : HOLD;
               end
            end
            FLUSH: begin
               if (slot_free) begin
                  out_valid_reg <= 1'b1;
                  out_wdata_reg <= window;
                  out_y_reg     <= held_y_reg;
                  out_blk_reg   <= held_blk_reg;
                  out_last_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_valid      = out_valid_reg;
   assign out_wdata      = out_wdata_reg;
   assign out_waddrY     = out_y_reg;
   assign out_waddrBlock = out_blk_reg;
   assign out_last       = out_last_reg;
   assign busy           = (state_reg != IDLE) || out_valid_reg;

endmodule

// File: tb/tb_window_align_stream.sv
// Directed bench for window_align_stream (WORDS=4): scoreboard of expected windows
// built from accepted beats, plus hand-computed windows for key rows.
module tb_window_align_stream;

   localparam int W  = 4;
   localparam int WS = 8;
   localparam int IW = 10;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [1:0]      cfg_offset;
   logic            in_valid;
   logic            in_ready;
   logic [W*WS-1:0] in_wdata;
   logic [IW-1:0]   in_waddrY;
   logic [IW-1:0]   in_waddrBlock;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [W*WS-1:0] out_wdata;
   logic [IW-1:0]   out_waddrY;
   logic [IW-1:0]   out_waddrBlock;
   logic            out_last;
   logic            busy;

   always #5 clk = ~clk;

   window_align_stream #(.WORDS(W), .WORD_SIZE(WS), .INDEX_WIDTH(IW)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_offset(cfg_offset),
      .in_valid(in_valid), .in_ready(in_ready), .in_wdata(in_wdata),
      .in_waddrY(in_waddrY), .in_waddrBlock(in_waddrBlock), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
      .out_waddrY(out_waddrY), .out_waddrBlock(out_waddrBlock), .out_last(out_last),
      .busy(busy)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [9:0]  y;
      logic [9:0]  blk;
      logic        last;
   } win_t;

   win_t        exp_q[$];
   logic [31:0] obs_q[$];
   int          total  = 0;
   int          passed = 0;

   logic [31:0] m_held;
   logic [9:0]  m_y, m_blk;
   int          m_off;
   bit          m_in_row = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] win(input logic [31:0] h, input logic [31:0] c, input int off);
      logic [31:0] r;
      int idx;
      r = '0;
      for (int x = 0; x < W; x++) begin
         idx = x + off;
         if (idx < W) r[x*8 +: 8] = h[idx*8 +: 8];
         else         r[x*8 +: 8] = c[(idx-W)*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] bt(input logic [7:0] base);
      return {base + 8'd3, base + 8'd2, base + 8'd1, base};
   endfunction

   function automatic logic [31:0] obs(input int i);
      if (i < obs_q.size()) return obs_q[i];
      return 'x;
   endfunction

   // Monitor/scoreboard: pops on every output handshake, models every accepted beat.
   always @(negedge clk) begin
      win_t e;
      if (!reset_n) begin
         exp_q.delete();
         m_in_row = 0;
      end else begin
         if (out_valid && out_ready) begin
            $display("window data=%h y=%0d blk=%0d last=%0b", out_wdata, out_waddrY, out_waddrBlock, out_last);
            obs_q.push_back(out_wdata);
            if (exp_q.size() == 0) begin
               check("unexpected_window", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("win_data", out_wdata, e.data);
               check("win_y", out_waddrY, e.y);
               check("win_blk", out_waddrBlock, e.blk);
               check("win_last", out_last, e.last);
            end
         end
         if (in_valid && in_ready) begin
            if (!m_in_row) begin
               m_off    = int'(cfg_offset);
               m_in_row = 1;
            end else begin
               exp_q.push_back('{win(m_held, in_wdata, m_off), m_y, m_blk, 1'b0});
            end
            m_held = in_wdata;
            m_y    = in_waddrY;
            m_blk  = in_waddrBlock;
            if (in_last) begin
               exp_q.push_back('{win(m_held, 32'h0, m_off), m_y, m_blk, 1'b1});
               m_in_row = 0;
            end
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic [9:0] y, input logic [9:0] blk, input logic last);
      int n = 0;
      in_valid = 1'b1; in_wdata = d; in_waddrY = y; in_waddrBlock = blk; in_last = last;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] saved;
      reset_n = 1'b0; cfg_offset = 2'd0; in_valid = 1'b0; in_wdata = '0;
      in_waddrY = '0; in_waddrBlock = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_wdata", out_wdata, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      #1;
      check("idle_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Test 1: off=1, two-beat row
      cfg_offset = 2'd1; obs_q.delete();
      send(bt(8'h00), 10'd1, 10'd0, 1'b0);
      send(bt(8'h10), 10'd1, 10'd1, 1'b1);
      drain();
      check("t1_count", obs_q.size(), 2);
      check("t1_win0", obs(0), 32'h10030201);
      check("t1_win1", obs(1), 32'h00131211);

      // Test 2: off=0, three-beat row, busy timing
      cfg_offset = 2'd0; obs_q.delete();
      send(bt(8'h20), 10'd2, 10'd0, 1'b0);
      send(bt(8'h24), 10'd2, 10'd1, 1'b0);
      send(bt(8'h28), 10'd2, 10'd2, 1'b1);
      check("t2_busy_flush", busy, 1);
      @(posedge clk); #1;
      check("t2_flush_valid", out_valid, 1);
      check("t2_flush_last", out_last, 1);
      @(posedge clk); #1;
      check("t2_busy_drop", busy, 0);
      drain();
      check("t2_win0", obs(0), bt(8'h20));
      check("t2_win1", obs(1), bt(8'h24));
      check("t2_win2", obs(2), bt(8'h28));

      // Test 3: off=3, single-beat row
      cfg_offset = 2'd3; obs_q.delete();
      send(bt(8'h30), 10'd3, 10'd0, 1'b1);
      check("t3_flush_in_ready", in_ready, 0);
      check("t3_flush_no_out", out_valid, 0);
      @(posedge clk); #1;
      check("t3_valid", out_valid, 1);
      check("t3_data", out_wdata, 32'h00000033);
      check("t3_last", out_last, 1);
      drain();
      check("t3_count", obs_q.size(), 1);

      // Test 4: off=2, downstream stall mid-row
      cfg_offset = 2'd2; obs_q.delete();
      send(bt(8'h40), 10'd4, 10'd0, 1'b0);
      send(bt(8'h50), 10'd4, 10'd1, 1'b0);
      out_ready = 1'b0;
      saved = out_wdata;
      check("t4_stall_start", out_wdata, 32'h51504342);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t4_stall_valid", out_valid, 1);
         check("t4_stall_data", out_wdata, saved);
         check("t4_stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      send(bt(8'h60), 10'd4, 10'd2, 1'b0);
      send(bt(8'h70), 10'd4, 10'd3, 1'b1);
      drain();
      check("t4_count", obs_q.size(), 4);

      // Test 5: offset change mid-row is ignored until the next row
      cfg_offset = 2'd1; obs_q.delete();
      send(bt(8'h80), 10'd5, 10'd0, 1'b0);
      cfg_offset = 2'd2;
      send(bt(8'h90), 10'd5, 10'd1, 1'b0);
      send(bt(8'hA0), 10'd5, 10'd2, 1'b1);
      send(bt(8'hB0), 10'd6, 10'd0, 1'b0);
      send(bt(8'hC0), 10'd6, 10'd1, 1'b1);
      drain();
      check("t5_count", obs_q.size(), 5);
      check("t5_row1_off1", obs(0), 32'h90838281);
      check("t5_row2_off2", obs(3), 32'hC1C0B3B2);

      // Test 6: reset in HOLD with a pending window
      cfg_offset = 2'd2; out_ready = 1'b0; obs_q.delete();
      send(bt(8'hD0), 10'd7, 10'd0, 1'b0);
      send(bt(8'hE0), 10'd7, 10'd1, 1'b0);
      check("t6_pending", out_valid, 1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("t6_out_valid", out_valid, 0);
      check("t6_out_wdata", out_wdata, 0);
      check("t6_out_y", out_waddrY, 0);
      check("t6_out_blk", out_waddrBlock, 0);
      check("t6_out_last", out_last, 0);
      check("t6_busy", busy, 0);
      out_ready = 1'b1; cfg_offset = 2'd1;
      send(bt(8'hF0), 10'd8, 10'd0, 1'b0);
      send(bt(8'h11), 10'd8, 10'd1, 1'b1);
      drain();
      check("t6_count", obs_q.size(), 2);
      check("t6_win0", obs(0), 32'h11F3F2F1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
